// File: rtl/score_tracker_if.sv
// Bundle between game logic and score_tracker: enemy status and game control in,
// BCD scores and status flags out to the 7-segment driver.
interface score_tracker_if #(
  parameter int unsigned N_ENEMIES = 64,
  parameter int unsigned DIGITS    = 3
);
  logic [N_ENEMIES-1:0] alive;
  logic                 game_over;
  logic                 restart;
  logic [4*DIGITS-1:0]  score_bcd;
  logic [4*DIGITS-1:0]  high_bcd;
  logic                 new_record;
  logic                 busy;
  logic                 playing;

  // Game side: drives enemy status and control, reads the scores.
  modport master (
    output alive, game_over, restart,
    input  score_bcd, high_bcd, new_record, busy, playing
  );

  // Tracker side.
  modport slave (
    input  alive, game_over, restart,
    output score_bcd, high_bcd, new_record, busy, playing
  );
endinterface

// File: rtl/score_tracker.sv
// Score keeper for the enemy-wave game. Kills (1->0 on alive) are latched as
// sticky pending flags; a scanner visits one index per cycle and adds POINTS
// in BCD for each pending flag, tracking the session high score.
// Optional build macro SCORE_SATURATE_EN: clamp score at all 9s instead of
// wrapping modulo 10^DIGITS.
module score_tracker #(
  parameter int unsigned N_ENEMIES = 64,
  parameter int unsigned DIGITS    = 3,
  parameter int unsigned POINTS    = 1
) (
  input logic             CLOCK_50,
  input logic             reset,
  score_tracker_if.slave  bus
);
  localparam int unsigned IdxW   = $clog2(N_ENEMIES);
  localparam int unsigned ScoreW = 4 * DIGITS;
  localparam logic [IdxW-1:0]   IdxLast  = IdxW'(N_ENEMIES - 1);
  localparam logic [ScoreW-1:0] ScoreMax = {DIGITS{4'd9}};

  localparam logic [0:0] StPlay = 1'b0;
  localparam logic [0:0] StOver = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [N_ENEMIES-1:0] alive_q;
  logic [N_ENEMIES-1:0] pending_q, pending_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [ScoreW-1:0]    score_q, score_d;
  logic [ScoreW-1:0]    high_q, high_d;
  logic                 rec_q, rec_d;
  logic                 busy_q;

  logic [N_ENEMIES-1:0] kill;
  logic [N_ENEMIES-1:0] clr_mask;
  logic                 scoring;
  logic                 hit;
  logic [ScoreW-1:0]    sum_bcd;
  logic                 sum_carry;
  logic [ScoreW-1:0]    score_next;
  logic [4:0]           dig_sum;
  logic [3:0]           dig_carry;

  // FSM next state; restart wins over game_over.
  always_comb begin
    state_d = state_q;
    if (bus.restart) begin
      state_d = StPlay;
    end else if (state_q == StPlay && bus.game_over) begin
      state_d = StOver;
    end
  end

  // Scoring only runs in PLAY on a cycle that is neither clearing nor freezing.
  always_comb begin
    scoring  = (state_q == StPlay) && !bus.restart && !bus.game_over;
    kill     = alive_q & ~bus.alive;
    hit      = scoring && pending_q[idx_q];
    clr_mask = '0;
    if (hit) begin
      clr_mask[idx_q] = 1'b1;
    end
  end

  // Pending flags and scanner index; a same-cycle kill keeps its flag set.
  always_comb begin
    pending_d = '0;
    idx_d     = idx_q;
    if (bus.restart) begin
      idx_d = '0;
    end else if (scoring) begin
      pending_d = (pending_q & ~clr_mask) | kill;
      idx_d     = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end
  end

  // BCD add of POINTS with ripple carry; carry out of the MSD is the wrap.
  always_comb begin
    sum_bcd   = '0;
    dig_sum   = '0;
    dig_carry = 4'(POINTS);
    for (int d = 0; d < DIGITS; d++) begin
      dig_sum = {1'b0, score_q[4*d +: 4]} + {1'b0, dig_carry};
      if (dig_sum >= 5'd10) begin
        sum_bcd[4*d +: 4] = 4'(dig_sum - 5'd10);
        dig_carry         = 4'd1;
      end else begin
        sum_bcd[4*d +: 4] = dig_sum[3:0];
        dig_carry         = 4'd0;
      end
    end
    sum_carry = (dig_carry != 4'd0);
  end

  // Score and high-score next state. Packed BCD with the MSD on top orders
  // exactly like the value, so a plain unsigned compare is the digit-wise one.
  always_comb begin
    score_next = score_q;
    if (hit) begin
`ifdef SCORE_SATURATE_EN
      score_next = sum_carry ? ScoreMax : sum_bcd;
`else
      score_next = sum_bcd;
`endif
    end
    rec_d   = hit && (score_next > high_q);
    high_d  = rec_d ? score_next : high_q;
    score_d = bus.restart ? '0 : score_next;
  end

  // State registers; alive_q always follows alive so reset/restart see no kill.
  always_ff @(posedge CLOCK_50) begin
    alive_q <= bus.alive;
    if (reset) begin
      state_q   <= StPlay;
      pending_q <= '0;
      idx_q     <= '0;
      score_q   <= '0;
      high_q    <= '0;
      rec_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      score_q   <= score_d;
      high_q    <= high_d;
      rec_q     <= rec_d;
      busy_q    <= |pending_d;
    end
  end

  assign bus.score_bcd  = score_q;
  assign bus.high_bcd   = high_q;
  assign bus.new_record = rec_q;
  assign bus.busy       = busy_q;
  assign bus.playing    = (state_q == StPlay);

endmodule

// File: tb/tb_score_tracker.sv
// Scoreboard bench for score_tracker: stimulus pushes the expected score/high/
// record triple for every score change it causes; monitors pop on each change.
module tb_score_tracker;
  logic CLOCK_50;
  logic reset;

  score_tracker_if #(.N_ENEMIES(64), .DIGITS(3)) bus_a ();
  score_tracker_if #(.N_ENEMIES(8),  .DIGITS(2)) bus_b ();

  score_tracker #(.N_ENEMIES(64), .DIGITS(3), .POINTS(1)) dut_a (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus_a)
  );

  score_tracker #(.N_ENEMIES(8), .DIGITS(2), .POINTS(7)) dut_b (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus_b)
  );

  typedef struct packed {
    logic [11:0] score;
    logic [11:0] high;
    logic        rec;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  int          n_chk = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;
  logic [11:0] prev_a = '0;
  logic [7:0]  prev_b = '0;

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  function automatic logic [11:0] bcd3(input int v);
    logic [11:0] r;
    r[11:8] = 4'((v / 100) % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  function automatic exp_t mk(input int s, input int h, input bit r);
    exp_t e;
    e.score = bcd3(s);
    e.high  = bcd3(h);
    e.rec   = r;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Wait (bounded) until the chosen scoreboard queue has been consumed.
  task automatic drain(input bit sel_b, input int lim, input string name);
    int n = 0;
    while (((sel_b ? q_b.size() : q_a.size()) != 0) && n < lim) begin
      @(negedge CLOCK_50);
      #1;
      n++;
    end
    chk(name, 32'(sel_b ? q_b.size() : q_a.size()), 32'd0);
  endtask

  // Monitor for the 3-digit instance.
  always @(negedge CLOCK_50) begin
    exp_t e;
    if (mon_en && !reset) begin
      if (bus_a.score_bcd !== prev_a) begin
        if (q_a.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL a_unexpected: score %0h, expected no change", bus_a.score_bcd);
        end else begin
          e = q_a.pop_front();
          chk("a_score", 32'(bus_a.score_bcd), 32'(e.score));
          chk("a_high", 32'(bus_a.high_bcd), 32'(e.high));
          chk("a_new_record", 32'(bus_a.new_record), 32'(e.rec));
        end
      end else if (bus_a.new_record) begin
        n_chk++;
        n_err++;
        $display("FAIL a_spurious_record: new_record 1, expected 0");
      end
    end
    prev_a = bus_a.score_bcd;
  end

  // Monitor for the 2-digit instance.
  always @(negedge CLOCK_50) begin
    exp_t e;
    if (mon_en && !reset) begin
      if (bus_b.score_bcd !== prev_b) begin
        if (q_b.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL b_unexpected: score %0h, expected no change", bus_b.score_bcd);
        end else begin
          e = q_b.pop_front();
          chk("b_score", 32'(bus_b.score_bcd), 32'(e.score[7:0]));
          chk("b_high", 32'(bus_b.high_bcd), 32'(e.high[7:0]));
          chk("b_new_record", 32'(bus_b.new_record), 32'(e.rec));
        end
      end else if (bus_b.new_record) begin
        n_chk++;
        n_err++;
        $display("FAIL b_spurious_record: new_record 1, expected 0");
      end
    end
    prev_b = bus_b.score_bcd;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kills10[10] = '{0, 7, 13, 20, 27, 34, 41, 48, 55, 63};
    int hi_b;
    int s_b;
    int e_b;
    reset            = 1'b1;
    bus_a.alive      = '1;
    bus_a.restart    = 1'b0;
    bus_a.game_over  = 1'b0;
    bus_b.alive      = '1;
    bus_b.restart    = 1'b0;
    bus_b.game_over  = 1'b0;
    repeat (3) tick();

    // Reset values.
    chk("rst_score", 32'(bus_a.score_bcd), 32'h0);
    chk("rst_high", 32'(bus_a.high_bcd), 32'h0);
    chk("rst_new_record", 32'(bus_a.new_record), 32'h0);
    chk("rst_busy", 32'(bus_a.busy), 32'h0);
    chk("rst_playing", 32'(bus_a.playing), 32'h1);
    chk("rst_b_score", 32'(bus_b.score_bcd), 32'h0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Single kill of enemy 5, then a respawn that must not score.
    q_a.push_back(mk(1, 1, 1'b1));
    bus_a.alive[5] = 1'b0;
    drain(1'b0, 67, "single_kill_latency");
    bus_a.alive[5] = 1'b1;
    repeat (70) tick();
    chk("respawn_score", 32'(bus_a.score_bcd), 32'h001);
    chk("respawn_busy", 32'(bus_a.busy), 32'h0);

    // Restart, then ten simultaneous kills.
    q_a.push_back(mk(0, 1, 1'b0));
    bus_a.restart = 1'b1;
    tick();
    bus_a.restart = 1'b0;
    drain(1'b0, 4, "restart1_drain");
    for (int j = 1; j <= 10; j++) q_a.push_back(mk(j, (j > 1) ? j : 1, j > 1));
    for (int j = 0; j < 10; j++) bus_a.alive[kills10[j]] = 1'b0;
    tick();
    tick();
    chk("multi_busy_high", 32'(bus_a.busy), 32'h1);
    drain(1'b0, 68, "multi_kill_latency");
    chk("multi_busy_low", 32'(bus_a.busy), 32'h0);
    chk("multi_score", 32'(bus_a.score_bcd), 32'h010);

    // Enemy 3 killed again on the very edge its flag is being cleared.
    q_a.push_back(mk(0, 10, 1'b0));
    tick();
    bus_a.restart = 1'b1;
    tick();
    bus_a.restart = 1'b0;
    tick();
    bus_a.alive[3] = 1'b0;
    tick();
    bus_a.alive[3] = 1'b1;
    tick();
    bus_a.alive[3] = 1'b0;
    q_a.push_back(mk(1, 10, 1'b0));
    q_a.push_back(mk(2, 10, 1'b0));
    drain(1'b0, 75, "set_wins_drain");
    chk("set_wins_score", 32'(bus_a.score_bcd), 32'h002);
    chk("restart_high_kept", 32'(bus_a.high_bcd), 32'h010);

    // Four kills latched, then game_over before the scanner reaches them.
    q_a.push_back(mk(0, 10, 1'b0));
    bus_a.restart = 1'b1;
    tick();
    bus_a.restart = 1'b0;
    drain(1'b0, 4, "restart3_drain");
    for (int j = 44; j < 48; j++) bus_a.alive[j] = 1'b0;
    tick();
    tick();
    bus_a.game_over = 1'b1;
    tick();
    chk("over_playing", 32'(bus_a.playing), 32'h0);
    chk("over_busy", 32'(bus_a.busy), 32'h0);
    bus_a.alive[50] = 1'b0;
    repeat (70) tick();
    chk("over_score", 32'(bus_a.score_bcd), 32'h000);

    // restart and game_over together: restart wins.
    bus_a.restart = 1'b1;
    tick();
    chk("restart_prio_playing", 32'(bus_a.playing), 32'h1);
    bus_a.restart   = 1'b0;
    bus_a.game_over = 1'b0;
    repeat (70) tick();
    chk("dead_no_points", 32'(bus_a.score_bcd), 32'h000);

    // Reset with twenty kills pending.
    bus_a.alive = '1;
    tick();
    bus_a.restart = 1'b1;
    tick();
    bus_a.restart = 1'b0;
    for (int j = 20; j < 40; j++) bus_a.alive[j] = 1'b0;
    tick();
    tick();
    chk("pre_reset_busy", 32'(bus_a.busy), 32'h1);
    reset = 1'b1;
    tick();
    chk("mid_reset_score", 32'(bus_a.score_bcd), 32'h0);
    chk("mid_reset_high", 32'(bus_a.high_bcd), 32'h0);
    chk("mid_reset_busy", 32'(bus_a.busy), 32'h0);
    chk("mid_reset_record", 32'(bus_a.new_record), 32'h0);
    chk("mid_reset_playing", 32'(bus_a.playing), 32'h1);
    reset = 1'b0;
    repeat (70) tick();
    chk("post_reset_score", 32'(bus_a.score_bcd), 32'h0);

    // DIGITS=2, POINTS=7: fifteen sequential kills of enemy 1.
    hi_b = 0;
    for (int k = 1; k <= 15; k++) begin
      s_b = 7 * k;
`ifdef SCORE_SATURATE_EN
      e_b = (s_b > 99) ? 99 : s_b;
`else
      e_b = s_b % 100;
`endif
      q_b.push_back(mk(e_b, (e_b > hi_b) ? e_b : hi_b, e_b > hi_b));
      if (e_b > hi_b) hi_b = e_b;
      bus_b.alive[1] = 1'b0;
      drain(1'b1, 14, "b_kill_latency");
      bus_b.alive[1] = 1'b1;
      tick();
      tick();
    end
`ifdef SCORE_SATURATE_EN
    chk("b_sat_score", 32'(bus_b.score_bcd), 32'h99);
    chk("b_sat_high", 32'(bus_b.high_bcd), 32'h99);
    bus_b.alive[1] = 1'b0;
    repeat (14) tick();
    chk("b_sat_hold", 32'(bus_b.score_bcd), 32'h99);
    chk("b_sat_busy", 32'(bus_b.busy), 32'h0);
`else
    chk("b_wrap_score", 32'(bus_b.score_bcd), 32'h05);
    chk("b_wrap_high", 32'(bus_b.high_bcd), 32'h98);
`endif
    repeat (4) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
